// File: rtl/ped_req_ctl_pkg.sv
// Shared types and widths for the pedestrian request controller.
package ped_req_ctl_pkg;

    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

endpackage

// File: rtl/ped_req_ctl_btn_debounce.sv
// Two-flop synchroniser plus counter debounce; emits a one-cycle pulse when
// the debounced level rises. Reusable for any active-high push button.
module btn_debounce #(
    parameter int DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_evt_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            // The level only changes after DB_CYCLES consecutive disagreeing samples.
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_evt_o = press_q;

endmodule

// File: rtl/ped_req_ctl.sv
// Pedestrian request conditioning for the light controller: debounced button,
// latched request held until Pg serves it, cooldown spacing and wait timer.
module ped_req_ctl
    import ped_req_ctl_pkg::*;
#(
    parameter int CLK_PER_SEC = 1000,
    parameter int DB_CYCLES   = 20,
    parameter int COOLDOWN_S  = 10,
    parameter int PULSE_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              Pg,
    output logic              N,
    output logic              req_pending,
    output logic [WAIT_W-1:0] wait_s
);

    localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int CD_W  = (COOLDOWN_S > 1) ? $clog2(COOLDOWN_S + 1) : 1;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              shadow_q, shadow_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              n_q, n_d;
    logic              pend_q, pend_d;
    logic              press;
    logic              sec_tick;
    logic              enter_armed;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn),
        .press_evt_o (press)
    );

    assign sec_tick = (presc_q == PRE_W'(CLK_PER_SEC - 1));
    assign presc_d  = sec_tick ? '0 : presc_q + PRE_W'(1);

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        shadow_d = shadow_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                if (press) state_d = ARMED;
            end
            ARMED: begin
                if (sec_tick && (wait_q != '1)) wait_d = wait_q + WAIT_W'(1);
                if (Pg) state_d = SERVING;
            end
            SERVING: begin
                if (!Pg) begin
                    state_d = COOLDOWN;
                    cd_d    = CD_W'(COOLDOWN_S);
                end
            end
            default: begin
                // A press arriving on the exit cycle itself still counts as queued.
                if (cd_q == '0) begin
                    state_d  = (shadow_q || press) ? ARMED : IDLE;
                    shadow_d = 1'b0;
                end else begin
                    if (sec_tick) cd_d = cd_q - CD_W'(1);
                    if (press) shadow_d = 1'b1;
                end
            end
        endcase

        enter_armed = (state_d == ARMED) && (state_q != ARMED);
        if (enter_armed) wait_d = '0;

        n_d    = (PULSE_MODE != 0) ? enter_armed : (state_d == ARMED);
        pend_d = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cd_q     <= '0;
            shadow_q <= 1'b0;
            wait_q   <= '0;
            n_q      <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cd_q     <= cd_d;
            shadow_q <= shadow_d;
            wait_q   <= wait_d;
            n_q      <= n_d;
            pend_q   <= pend_d;
        end
    end

    assign N           = n_q;
    assign req_pending = pend_q;
    assign wait_s      = wait_q;

endmodule

// File: tb/tb_ped_req_ctl.sv
// Directed scenarios plus random button/Pg traffic for ped_req_ctl in both N modes,
// checked every cycle against a tick-counting reference model.
module tb_ped_req_ctl;

    localparam int CPS = 50;
    localparam int DB  = 20;
    localparam int CDS = 10;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_SERVE = 2;
    localparam int P_COOL  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       pg  = 1'b0;
    logic       n0, pend0, n1, pend1;
    logic [7:0] w0, w1;

    always #5 clk = ~clk;

    ped_req_ctl #(
        .CLK_PER_SEC (CPS),
        .DB_CYCLES   (DB),
        .COOLDOWN_S  (CDS),
        .PULSE_MODE  (0)
    ) dut_lvl (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .Pg          (pg),
        .N           (n0),
        .req_pending (pend0),
        .wait_s      (w0)
    );

    ped_req_ctl #(
        .CLK_PER_SEC (CPS),
        .DB_CYCLES   (DB),
        .COOLDOWN_S  (CDS),
        .PULSE_MODE  (1)
    ) dut_pls (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .Pg          (pg),
        .N           (n1),
        .req_pending (pend1),
        .wait_s      (w1)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n1_rises = 0;

    // Reference model state: time is tracked as counts of elapsed second ticks.
    bit m_s1, m_s2, m_lvl, m_press, m_n1;
    int m_run, m_cyc, m_ticks, m_ph, m_wait, m_wmark, m_cmark;
    bit m_shadow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit sync, pr, tick;
        int prev;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_press = 0; m_n1 = 0;
            m_cyc = 0; m_ticks = 0; m_ph = P_IDLE; m_wait = 0;
            m_wmark = 0; m_cmark = 0; m_shadow = 0;
            return;
        end
        sync = m_s2;
        pr   = m_press;
        tick = ((m_cyc % CPS) == CPS - 1);
        prev = m_ph;
        m_s2 = m_s1;
        m_s1 = btn;
        m_press = 0;
        if (sync != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl   = sync;
                m_run   = 0;
                m_press = sync;
            end
        end else begin
            m_run = 0;
        end
        m_cyc++;
        case (prev)
            P_IDLE:  if (pr) m_ph = P_ARMED;
            P_ARMED: if (pg) m_ph = P_SERVE;
            P_SERVE: if (!pg) m_ph = P_COOL;
            default: begin
                if (m_ticks - m_cmark >= CDS) begin
                    m_ph     = (m_shadow || pr) ? P_ARMED : P_IDLE;
                    m_shadow = 0;
                end else if (pr) begin
                    m_shadow = 1;
                end
            end
        endcase
        if (tick) m_ticks++;
        if (prev == P_ARMED) m_wait = (m_ticks - m_wmark > 255) ? 255 : m_ticks - m_wmark;
        if (m_ph == P_COOL && prev != P_COOL) m_cmark = m_ticks;
        m_n1 = (m_ph == P_ARMED) && (prev != P_ARMED);
        if (m_n1) begin
            m_wmark = m_ticks;
            m_wait  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (n1 === 1'b1) n1_rises++;
        check("model_level_mode", {22'd0, n0, pend0, w0},
              {22'd0, (m_ph == P_ARMED), (m_ph == P_ARMED), 8'(m_wait)});
        check("model_pulse_mode", {22'd0, n1, pend1, w1},
              {22'd0, m_n1, (m_ph == P_ARMED), 8'(m_wait)});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int k;
        int rises0;

        // Reset hold with the button already pressed.
        rst = 1'b0; btn = 1'b1; pg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_N", n0, 0);
            check("rst_pend", pend0, 0);
            check("rst_wait", w0, 0);
        end
        rst = 1'b1;
        k = 0;
        while (n0 !== 1'b1 && k < 100) begin step(); k++; end
        check("reset_release_latency", k, 23);
        check("pulse_N_on_entry", n1, 1);
        step();
        check("pulse_N_one_cycle", n1, 0);
        check("pulse_pend_held", pend1, 1);
        $display("scenario reset_hold: N after %0d cycles", k);

        btn = 1'b0; pg = 1'b1;
        run(5);
        check("served_N", n0, 0);
        check("served_pend", pend0, 0);
        pg = 1'b0;
        run(12 * CPS);

        // Bounce: 5-cycle toggles for 100 cycles, then held high.
        n1_rises = 0;
        for (int t = 0; t < 100; t++) begin
            btn = ((t / 5) % 2 == 0);
            step();
            check("bounce_N_low", n0, 0);
        end
        btn = 1'b1;
        k = 0;
        while (n0 !== 1'b1 && k < 100) begin step(); k++; end
        check("bounce_latency", k, 23);
        check("bounce_single_request", n1_rises, 1);
        $display("scenario bounce: N after %0d cycles, %0d pulses", k, n1_rises);

        // Wait counter saturation over 300 s.
        run(300 * CPS);
        check("wait_saturated", w0, 255);
        check("wait_N_held", n0, 1);
        check("wait_pend_held", pend0, 1);
        pg = 1'b1; btn = 1'b0;
        step();
        check("wait_served_N", n0, 0);
        check("wait_hold_value", w0, 255);
        run(30);
        $display("scenario wait_counter: wait_s=%0d", w0);

        // Cooldown with a shadow press at 3 s and a second absorbed press.
        pg = 1'b0;
        n1_rises = 0;
        k = 0;
        rises0 = 0;
        while (n0 !== 1'b1 && k < 20 * CPS) begin
            if (k == 3 * CPS)      btn = 1'b1;
            if (k == 3 * CPS + 30) btn = 1'b0;
            if (k == 3 * CPS + 60) btn = 1'b1;
            if (k == 3 * CPS + 90) btn = 1'b0;
            step();
            k++;
        end
        check("cool_window", ((k >= 9 * CPS) && (k <= 10 * CPS + 2)), 1);
        check("cool_pend", pend0, 1);
        check("cool_one_pulse", n1_rises, 1);
        pg = 1'b1;
        run(3);
        pg = 1'b0;
        run(12 * CPS);
        check("cool_no_extra_N", n0, 0);
        check("cool_no_extra_pulse", n1_rises, 1);
        $display("scenario cooldown: N after %0d cycles from Pg fall", k);

        // Mid-request reset.
        btn = 1'b1;
        run(30);
        btn = 1'b0;
        k = 0;
        while (w0 !== 8'd7 && k < 12 * CPS) begin step(); k++; end
        check("midrst_wait_reached", w0, 7);
        rst = 1'b0;
        step();
        check("midrst_N", n0, 0);
        check("midrst_wait", w0, 0);
        check("midrst_pend", pend0, 0);
        rst = 1'b1;
        pg = 1'b1;
        run(5);
        pg = 1'b0;
        run(30);
        check("midrst_pg_no_effect", n0, 0);
        $display("scenario mid_reset: wait_s=%0d after reset", w0);

        // Random traffic.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            len = $urandom_range(3, 150);
            btn = ~btn;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 299) == 0) pg = ~pg;
                step();
            end
        end
        $display("scenario random: done, %0d checks so far", chk_cnt);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ped_req_ctl.md
Name: ped_req_ctl

Overview:
Conditions the raw pedestrian push-button and drives the N request input of the ltc light controller directly upstream of it. The raw button is synchronised and debounced, and a press is latched into a request. The request is presented to ltc until the pedestrian phase (Pg) is served, and a cooldown enforces a minimum spacing between served requests. A saturating wait-time counter in seconds is exported for a "wait" indicator.

Parameters:
CLK_PER_SEC, 1000, clk cycles per second (1 kHz system clock); prescaler terminal count.
DB_CYCLES, 20, consecutive identical synchronised samples required to accept a button level change.
COOLDOWN_S, 10, seconds after Pg falls before a new request may be presented.
PULSE_MODE, 0, 0 = N is a level held until Pg rises; 1 = N is a single-cycle pulse on request issue.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
btn  in  1  raw asynchronous pedestrian button, active-high, bouncing.
Pg  in  1  pedestrian-green from ltc; used as service acknowledge.
N  out  1  pedestrian request to ltc.
req_pending  out  1  1 while a request is latched but not yet served.
wait_s  out  8  whole seconds since the current request was latched; saturates at 255.

Behaviour:
- Reset (rst=0 at a clk edge) forces the following values; all are valid on the edge where rst is sampled low:
  - N=0, req_pending=0, wait_s=0, state=IDLE.
  - Sync flops=0, debounced level=0, debounce count=0, prescaler=0, cooldown count=0, shadow flag=0.
- Reset asserted mid-operation aborts any request, count or cooldown. No request survives reset.
- Synchroniser: 2 flops on btn. Debounce operates on the second flop output only.
- Debounce:
  - Counter increments while the sync output differs from the debounced level, and clears when it equals it.
  - On reaching DB_CYCLES, the debounced level flips and the counter clears.
  - A press event is the 0->1 transition of the debounced level, lasting one cycle. Release is ignored.
  - Minimum latency from a stable btn edge to the press event is 2+DB_CYCLES cycles.
- Prescaler: 0..CLK_PER_SEC-1 free-running, producing a one-cycle sec_tick at terminal count. It runs continuously after reset.
- FSM states IDLE, ARMED, SERVING, COOLDOWN:
  - IDLE: press -> ARMED. Pg=1 while IDLE -> stay IDLE; no request is needed.
  - ARMED:
    - req_pending=1.
    - wait_s clears on entry, then increments on each sec_tick, saturating at 255.
    - A further press in ARMED is absorbed; it does not create a second request.
    - Pg rising (Pg=1 sampled while ARMED) -> SERVING.
  - SERVING: req_pending=0, wait_s holds its last value. Pg=0 -> COOLDOWN with the cooldown count loaded to COOLDOWN_S.
  - COOLDOWN:
    - Cooldown count decrements on each sec_tick.
    - A press sets a one-deep shadow flag; further presses are absorbed.
    - At count=0, go to ARMED if the shadow flag is set (and clear it), else go to IDLE.
    - COOLDOWN_S=0 means exit on the next cycle.
    - Pg re-rising during COOLDOWN is ignored.
- N output:
  - PULSE_MODE=0: N=1 exactly while the state is ARMED (registered, so it asserts the cycle after the press event).
  - PULSE_MODE=1: N=1 for one cycle on every entry to ARMED, including the entry from COOLDOWN.
- Simultaneous events:
  - Press and Pg rise in the same IDLE cycle -> ARMED, then SERVING on the next cycle.
  - sec_tick and the ARMED entry in the same cycle -> wait_s=0; the entry wins.
- All outputs are registered; there is no combinational path from btn or Pg to N.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ARMED=2'd1, SERVING=2'd2, COOLDOWN=2'd3) and WAIT_W=8.
- Sub-module btn_debounce (synchroniser plus debounce counter, parameter DB_CYCLES, output press_evt). It is reusable for other buttons.
- Prescaler and FSM stay in the top level.

Test Plan:
- Reset hold: rst=0 for 3 cycles with btn=1 -> N=0, req_pending=0, wait_s=0 throughout; after release with btn still 1, the press event fires 22 cycles later (DB_CYCLES=20) and N=1 on the next cycle.
- Bounce rejection: btn toggles every 5 cycles for 100 cycles, then stays 1 -> exactly one request; N stays 0 until 22 cycles after the final edge.
- Wait counter: press, hold Pg=0 for 300 s -> wait_s counts 1..255 and stays 255; N stays 1; on Pg=1, N=0 the next cycle and wait_s holds 255.
- Cooldown and shadow request: serve a request, drop Pg, press at 3 s into cooldown -> N stays 0 until 10 s after Pg fell, then N=1 and req_pending=1; a second press in cooldown gives no extra request.
- PULSE_MODE=1: a press gives N high for exactly 1 cycle while req_pending stays 1 until Pg=1.
- Mid-request reset: in ARMED with wait_s=7, rst=0 for 1 cycle -> N=0, wait_s=0, state IDLE; a later Pg pulse has no effect.
